// File: rtl/seq_mem_d2_loader_if.sv
// seq_mem_d2_loader_if: stream input plus seq_mem_d2 read/write port seen by the loader.
//   master : loader side (drives in_ready, address, write data/enable, read enable)
//   slave  : harness side (drives in_valid/in_data, write_done, read_data/read_done)
interface seq_mem_d2_loader_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned D0_IDX_SIZE = 4,
    parameter int unsigned D1_IDX_SIZE = 4
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [D0_IDX_SIZE-1:0] addr0;
    logic [D1_IDX_SIZE-1:0] addr1;
    logic [WIDTH-1:0]       write_data;
    logic                   write_en;
    logic                   write_done;
    logic                   read_en;
    logic [WIDTH-1:0]       read_data;
    logic                   read_done;

    modport master (
        input  in_valid, in_data, write_done, read_data, read_done,
        output in_ready, addr0, addr1, write_data, write_en, read_en
    );

    modport slave (
        output in_valid, in_data, write_done, read_data, read_done,
        input  in_ready, addr0, addr1, write_data, write_en, read_en
    );
endinterface

// File: rtl/seq_mem_d2_loader.sv
// seq_mem_d2_loader: fills a seq_mem_d2 from a valid/ready word stream in row-major
// order (addr0 outer, addr1 inner) and raises loaded when every element is written.
// Ports:
//   clk, reset (async, active-high)
//   start    : begin a load, honoured only in IDLE or DONE
//   bus      : seq_mem_d2_loader_if.master (stream in + memory write/read port)
//   busy     : load in progress
//   loaded   : all D0_SIZE*D1_SIZE words written
//   count    : words committed so far
//   mismatch : sticky readback compare error
// Optional feature macro: SEQ_MEM_D2_LOADER_READBACK_EN (read back and compare each word).
module seq_mem_d2_loader #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned D0_SIZE     = 8,
    parameter int unsigned D1_SIZE     = 12,
    parameter int unsigned D0_IDX_SIZE = 4,
    parameter int unsigned D1_IDX_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    seq_mem_d2_loader_if.master        bus,
    output logic                       busy,
    output logic                       loaded,
    output logic [15:0]                count,
    output logic                       mismatch
);
    localparam int unsigned COUNT_W = 16;
    localparam logic [D0_IDX_SIZE-1:0] LAST_ROW = D0_IDX_SIZE'(D0_SIZE - 1);
    localparam logic [D1_IDX_SIZE-1:0] LAST_COL = D1_IDX_SIZE'(D1_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        WAIT_W,
`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
        READ,
        WAIT_R,
`endif
        DONE
    } state_t;

    state_t                 state, state_n;
    logic [D0_IDX_SIZE-1:0] addr0_n;
    logic [D1_IDX_SIZE-1:0] addr1_n;
    logic [WIDTH-1:0]       data_n;
    logic [COUNT_W-1:0]     count_n;
    logic                   mismatch_n;
    logic                   mismatch_q;
    logic                   advance;

    // Next-state, counters and captured data
    always_comb begin
        state_n    = state;
        addr0_n    = bus.addr0;
        addr1_n    = bus.addr1;
        data_n     = bus.write_data;
        count_n    = count;
        mismatch_n = mismatch_q;
        advance    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = ACCEPT;
                    addr0_n    = '0;
                    addr1_n    = '0;
                    count_n    = '0;
                    mismatch_n = 1'b0;
                end
            end
            ACCEPT: begin
                if (bus.in_valid && bus.in_ready) begin
                    data_n  = bus.in_data;
                    state_n = WRITE;
                end
            end
            WRITE: state_n = WAIT_W;
            WAIT_W: begin
                if (bus.write_done) begin
                    count_n = count + COUNT_W'(1);
`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
                    state_n = READ;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
            READ: state_n = WAIT_R;
            WAIT_R: begin
                if (bus.read_done) begin
                    if (bus.read_data != bus.write_data) begin
                        mismatch_n = 1'b1;
                    end
                    advance = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Row-major address step; the last element terminates the load
        if (advance) begin
            if (bus.addr1 == LAST_COL) begin
                addr1_n = '0;
                addr0_n = bus.addr0 + D0_IDX_SIZE'(1);
            end else begin
                addr1_n = bus.addr1 + D1_IDX_SIZE'(1);
            end
            if (bus.addr0 == LAST_ROW && bus.addr1 == LAST_COL) begin
                state_n = DONE;
            end else begin
                state_n = ACCEPT;
            end
        end
    end

    // State, datapath and registered status decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bus.addr0      <= '0;
            bus.addr1      <= '0;
            bus.write_data <= '0;
            bus.in_ready   <= 1'b0;
            bus.write_en   <= 1'b0;
            count          <= '0;
            mismatch_q     <= 1'b0;
            busy           <= 1'b0;
            loaded         <= 1'b0;
        end else begin
            state          <= state_n;
            bus.addr0      <= addr0_n;
            bus.addr1      <= addr1_n;
            bus.write_data <= data_n;
            bus.in_ready   <= (state_n == ACCEPT);
            bus.write_en   <= (state_n == WRITE);
            count          <= count_n;
            mismatch_q     <= mismatch_n;
            busy           <= (state_n != IDLE) && (state_n != DONE);
            loaded         <= (state_n == DONE);
        end
    end

`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.read_en <= 1'b0;
        end else begin
            bus.read_en <= (state_n == READ);
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_readback;

    // Read port exists only so both builds share one port list
    assign unused_readback = ^{bus.read_data, bus.read_done, mismatch_n, mismatch_q};
    assign bus.read_en     = 1'b0;
    assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mem_d2_loader.sv
// tb_seq_mem_d2_loader: directed bench for seq_mem_d2_loader with a behavioural
// seq_mem_d2 (write_done/read_done one cycle after the request, optional extra
// write stall, optional corruption of the word at (2,5)) and a stream source.
module tb_seq_mem_d2_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        loaded;
    logic [15:0] count;
    logic        mismatch;

    seq_mem_d2_loader_if #(.WIDTH(32), .D0_IDX_SIZE(4), .D1_IDX_SIZE(4)) bus ();

    seq_mem_d2_loader #(
        .WIDTH(32), .D0_SIZE(8), .D1_SIZE(12), .D0_IDX_SIZE(4), .D1_IDX_SIZE(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .loaded   (loaded),
        .count    (count),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [16][16];
    logic [7:0]  wlog [$];
    int          oob;
    int          rd_seen;
    int          wd_timer;
    int          rd_timer;
    logic [31:0] rd_val;
    int          wr_stall;
    bit          corrupt;
    bit          src_en;
    bit          src_rand;
    int          src_idx;
    logic [31:0] src_base;
    int          n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change only at the falling edge
    task automatic step();
        bit hs;
        hs = bus.in_valid && bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;
        if (wd_timer > 0) begin
            wd_timer--;
            if (wd_timer == 0) bus.write_done = 1'b1;
        end
        if (rd_timer > 0) begin
            rd_timer--;
            if (rd_timer == 0) begin
                bus.read_done = 1'b1;
                bus.read_data = rd_val;
            end
        end
        if (bus.write_en) begin
            mem[bus.addr0][bus.addr1] = bus.write_data;
            wlog.push_back({bus.addr0, bus.addr1});
            if (bus.addr0 >= 4'd8 || bus.addr1 >= 4'd12) oob++;
            wd_timer = 1 + wr_stall;
        end
        if (bus.read_en) begin
            rd_seen++;
            rd_val = mem[bus.addr0][bus.addr1];
            if (corrupt && bus.addr0 == 4'd2 && bus.addr1 == 4'd5) rd_val = rd_val ^ 32'h1;
            rd_timer = 1;
        end
        if (hs) src_idx++;
        if (!src_en) begin
            bus.in_valid = 1'b0;
        end else if (!(bus.in_valid && !hs)) begin
            bus.in_valid = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = bus.in_valid ? src_base + 32'(src_idx) : 32'hDEAD_0000 + 32'(src_idx);
        end
    endtask

    task automatic chk_zero(input string ctx);
        chk({ctx, "_write_en"}, bus.write_en, 0);
        chk({ctx, "_read_en"}, bus.read_en, 0);
        chk({ctx, "_in_ready"}, bus.in_ready, 0);
        chk({ctx, "_busy"}, busy, 0);
        chk({ctx, "_loaded"}, loaded, 0);
        chk({ctx, "_count"}, count, 0);
        chk({ctx, "_addr0"}, bus.addr0, 0);
        chk({ctx, "_addr1"}, bus.addr1, 0);
        chk({ctx, "_write_data"}, bus.write_data, 0);
        chk({ctx, "_mismatch"}, mismatch, 0);
    endtask

    task automatic begin_run(input logic [31:0] base, input bit rnd, input int stall, input bit bad);
        wlog.delete();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][c] = 32'hFFFF_FFFF;
        oob          = 0;
        src_idx      = 0;
        src_base     = base;
        src_rand     = rnd;
        wr_stall     = stall;
        corrupt      = bad;
        src_en       = 1'b1;
        bus.in_valid = 1'b0;
        start        = 1'b1;
        step();
        start        = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", bus.in_ready, 1);
        chk("start_count", count, 0);
        chk("start_loaded", loaded, 0);
        chk("start_mismatch", mismatch, 0);
    endtask

    task automatic wait_loaded(input int budget, output int cycles);
        cycles = 0;
        while (!loaded && cycles < budget) begin
            step();
            cycles++;
        end
        chk("loaded", loaded, 1);
        chk("done_busy", busy, 0);
        chk("done_count", count, 96);
    endtask

    task automatic wait_count(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (count != 16'(target) && k < budget) begin
            step();
            k++;
        end
        chk(tag, count, 64'(target));
    endtask

    task automatic chk_image(input string tag, input logic [31:0] base);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 12; c++)
                chk($sformatf("%s_mem_%0d_%0d", tag, r, c), mem[r][c], base + 32'(12 * r + c));
        chk({tag, "_writes"}, wlog.size(), 96);
        chk({tag, "_oob"}, oob, 0);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;
        bus.read_data  = '0;
        src_en = 1'b0; src_rand = 1'b0; src_idx = 0; src_base = '0;
        wr_stall = 0; corrupt = 1'b0; wd_timer = 0; rd_timer = 0; rd_val = '0;
        oob = 0; rd_seen = 0;

        step();
        step();
        chk_zero("rst_hold");
        reset = 1'b0;
        step();
        chk_zero("rst_release");

        // Full load, in_valid held high
        begin_run(32'h0, 1'b0, 0, 1'b0);
        step();
        chk("w0_write_en", bus.write_en, 1);
        chk("w0_in_ready", bus.in_ready, 0);
        chk("w0_write_data", bus.write_data, 0);
        chk("w0_addr", {bus.addr0, bus.addr1}, 0);
        for (int i = 0; i < 29; i++) step();
`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
        chk("count_at_30", count, 6);
`else
        chk("count_at_30", count, 10);
`endif
        wait_loaded(2000, n);
`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
        chk("load_cycles", 64'(n + 30), 480);
        chk("reads_issued", rd_seen, 96);
`else
        chk("load_cycles", 64'(n + 30), 288);
        chk("reads_issued", rd_seen, 0);
`endif
        chk("run1_mismatch", mismatch, 0);
        chk_image("run1", 32'h0);
        if (wlog.size() >= 96) begin
            chk("wrap_0_11", wlog[11], 8'h0B);
            chk("wrap_1_0", wlog[12], 8'h10);
            chk("last_7_11", wlog[95], 8'h7B);
        end

        // Random in_valid, write_done stalled by 3 cycles
        begin_run(32'h1000, 1'b1, 3, 1'b0);
        wait_loaded(5000, n);
        chk_image("bp", 32'h1000);

`ifdef SEQ_MEM_D2_LOADER_READBACK_EN
        // Corrupted readback at (2,5)
        begin_run(32'h3000, 1'b0, 0, 1'b1);
        wait_count("rb_reach29", 29, 1000);
        chk("rb_before", mismatch, 0);
        wait_count("rb_reach40", 40, 1000);
        chk("rb_after", mismatch, 1);
        wait_loaded(2000, n);
        chk("rb_done", mismatch, 1);
`endif

        // start during ACCEPT is ignored (begin_run also shows mismatch cleared)
        begin_run(32'h2000, 1'b0, 0, 1'b0);
        n = 0;
        while (!(bus.in_ready && count == 16'd40) && n < 1000) begin
            step();
            n++;
        end
        chk("si_accept_at_40", {bus.in_ready, count}, {1'b1, 16'd40});
        start = 1'b1;
        step();
        start = 1'b0;
        chk("si_busy", busy, 1);
        chk("si_count", count, 40);
        chk("si_write_en", bus.write_en, 1);
        wait_loaded(2000, n);
        chk_image("si", 32'h2000);

        // Asynchronous reset while waiting for write_done
        begin_run(32'h4000, 1'b0, 3, 1'b0);
        step();
        chk("mw_write_en", bus.write_en, 1);
        step();
        chk("mw_wait_busy", busy, 1);
        chk("mw_wait_write_en", bus.write_en, 0);
        reset = 1'b1;
        #1;
        chk_zero("rst_async");
        src_en = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk_zero("rst_after");
        step();
        chk("rst_idle", {busy, loaded, bus.in_ready}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
